// File: rtl/uart_tx_port.sv
// uart_tx_port: FIFO-buffered 8N1 UART transmitter on the CPU IO bus.
// Bytes pushed with wr_en go out LSB first on tx; status bits feed the IO read mux.
//
// state | meaning
// IDLE  | line high, waiting for a queued byte
// START | start bit (low)
// DATA  | 8 data bits, LSB first
// STOP  | stop bit (high); chains straight into START when more bytes are queued
module uart_tx_port #(
    parameter int CLKS_PER_BIT = 200,
    parameter int FIFO_DEPTH   = 16,
    parameter int CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [7:0]       wr_data,
    input  logic             clr_ovf,
    output logic             tx,
    output logic             busy,
    output logic             fifo_empty,
    output logic             fifo_full,
    output logic [CNT_W-1:0] fifo_count,
    output logic             overflow
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        shift_q, shift_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic [7:0]        fifo_mem_q [FIFO_DEPTH];

    logic push;
    logic pop;
    logic baud_last;
    logic fifo_has_data;

    // Fullness is the pre-edge value, so a push into a full FIFO is dropped
    // even when the FSM pops in the same cycle.
    assign push          = wr_en && (count_q != CNT_FULL);
    assign baud_last     = (baud_q == BAUD_LAST);
    assign fifo_has_data = (count_q != '0);

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        baud_d    = baud_last ? '0 : baud_q + 1'b1;
        pop       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                if (fifo_has_data) begin
                    pop     = 1'b1;
                    shift_d = fifo_mem_q[rd_ptr_q];
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (baud_last) begin
                    bit_idx_d = '0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (baud_last) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (baud_last) begin
                    if (fifo_has_data) begin
                        pop     = 1'b1;
                        shift_d = fifo_mem_q[rd_ptr_q];
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        overflow_d = overflow_q;
        if (wr_en && !push) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end
        // Line level follows the current state one cycle later.
        case (state_q)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_q[bit_idx_q];
            default:  tx_d = 1'b1;
        endcase
        busy_d = (state_q != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            baud_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            baud_q     <= baud_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            fifo_mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_FULL);
    assign fifo_count = count_q;
    assign overflow   = overflow_q;

endmodule
